// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, halt encoding and fetch state type for the CPU
package cpu_defs;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // The unused 2'd3 encoding is folded back to BOOT by the fetch FSM.
  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - pc-to-instruction port between fetch and instructionMemory
interface instruction_fetch_if;
  import cpu_defs::*;

  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] instruction_in;

  modport master (output pc_out, input  instruction_in);
  modport slave  (input  pc_out, output instruction_in);

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// rtl/instruction_fetch_pc_register.sv - program counter with async active-low reset and load enable
module pc_register
  import cpu_defs::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] pc_d_i,
  output logic [WORD_W-1:0] pc_q_o
);

  logic [WORD_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC ownership, instruction register, stall/redirect/halt control
module instruction_fetch
  import cpu_defs::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [WORD_W-1:0]   redirect_pc,
  instruction_fetch_if.master imem,
  output logic [WORD_W-1:0]   if_instruction,
  output logic [WORD_W-1:0]   if_pc,
  output logic [WORD_W-1:0]   if_pc_plus4,
  output logic                if_valid,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              pc_load;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] if_pc_q, if_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [15:0]       count_q, count_d;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (pc_load),
    .pc_d_i (pc_d),
    .pc_q_o (pc_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH_BOOT;
      instr_q  <= '0;
      if_pc_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_load  = 1'b0;
    pc_d     = pc_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;

    case (state_q)
      FETCH_BOOT: begin
        state_d = FETCH_RUN;
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = word_align(redirect_pc);
        end
      end

      // Redirect beats stall; the flushed slot keeps the old if_instruction/if_pc.
      FETCH_RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = word_align(redirect_pc);
          valid_d = 1'b0;
        end else if (stall) begin
          pc_load = 1'b0;
        end else if (imem.instruction_in != HALT_WORD) begin
          instr_d = imem.instruction_in;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          pc_load = 1'b1;
          pc_d    = pc_q + WORD_W'(INSTR_BYTES);
          count_d = count_q + 16'd1;
        end else begin
          state_d  = FETCH_HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
      end

      FETCH_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        if (redirect) begin
          pc_load  = 1'b1;
          pc_d     = word_align(redirect_pc);
          halted_d = 1'b0;
          state_d  = FETCH_RUN;
        end
      end

      default: begin
        state_d = FETCH_BOOT;
      end
    endcase
  end

  assign imem.pc_out    = pc_q;
  assign if_instruction = instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_q + WORD_W'(INSTR_BYTES);
  assign if_valid       = valid_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule
